shift_register_sequencer: RTL and testbench
===========================================

SHIFT_REGISTER_SEQUENCER -- requirements
Module: shift_register_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning pattern and register width.
REQ-002 SHALL have parameter CHECK_ENABLE, default 1, meaning readback compare enabled when 1 and mismatch tied 0 when 0.
REQ-003 SHALL have port clockpulse  input  1  sole clock, rising edge.
REQ-004 SHALL have port notclear  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request a sequence; sampled only in IDLE.
REQ-006 SHALL have port preset  input  WIDTH  initial pattern, latched on start acceptance.
REQ-007 SHALL have port steps  input  5  shift count 0..31, latched on start acceptance.
REQ-008 SHALL have port direction  input  1  0 = rotate right, 1 = rotate left; latched on start acceptance.
REQ-009 SHALL have port hold  input  1  pause shifting while high.
REQ-010 SHALL have port regOut  input  WIDTH  readback of the controlled shift register output.
REQ-011 SHALL have port enablePreset  output  1  load strobe to the register.
REQ-012 SHALL have port presetValue  output  WIDTH  latched pattern driven to the register.
REQ-013 SHALL have port shiftEnable  output  1  one rotate per high cycle.
REQ-014 SHALL have port shiftLeft  output  1  latched direction.
REQ-015 SHALL have port busy, done, mismatch  outputs  1 each  status flags.
REQ-016 SHALL have port expected  output  WIDTH  model of the register contents.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE, with all outputs decoded from registered state and latched data.
REQ-018 In IDLE, start=1 SHALL latch preset, steps and direction, clear mismatch, and go to LOAD; start in any other state SHALL be ignored.
REQ-019 LOAD SHALL last one cycle with enablePreset=1; expected <= latched preset; next state is DONE if steps==0, else SHIFT.
REQ-020 In SHIFT, shiftEnable SHALL equal !hold; each cycle with shiftEnable=1, the counter decrements and expected rotates.
REQ-021 Rotate right SHALL be {e[0],e[W-1:1]}; rotate left SHALL be {e[W-2:0],e[W-1]}.
REQ-022 SHIFT SHALL go to DONE on the cycle that issues the final shiftEnable (counter 1 -> 0); hold=1 SHALL freeze the counter and expected.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE; start during DONE SHALL be ignored.
REQ-024 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-025 Latency: start accepted at edge k gives enablePreset in cycle k+1, first shiftEnable in cycle k+2, and done in cycle k+2+steps+(hold cycles); steps=0 gives done in cycle k+2.
REQ-026 A compare-valid flag SHALL be set for the cycle after each enablePreset or shiftEnable; when that flag is set and regOut != expected, mismatch SHALL set.
REQ-027 mismatch SHALL be sticky until the next accepted start or reset; the compare for the final shift SHALL occur in the DONE cycle.
REQ-028 Steps counting SHALL be 5-bit unsigned with no wrap; steps=31 SHALL yield exactly 31 shifts.

Reset
REQ-029 notclear=0 at a rising edge SHALL force IDLE, counter=0, expected=0, latched registers=0, and every output 0, regardless of start or hold.
REQ-030 Reset mid-operation SHALL abort the sequence with no done pulse; after reset is released, a new start SHALL be accepted the next cycle.

Verification
REQ-031 Reset, then start with preset=11000, steps=3, direction=0, and a correct register model -> enablePreset 1 cycle; shiftEnable 3 cycles; expected 11000, 01100, 00110, 00011; done 1 cycle; mismatch=0.
REQ-032 steps=0 -> LOAD then DONE; no shiftEnable; done 2 cycles after start; busy high 2 cycles.
REQ-033 preset=11000, steps=5, direction=1, hold high 2 cycles mid-SHIFT -> 5 shiftEnable pulses; done delayed 2 cycles; final expected=11000.
REQ-034 regOut bit 0 stuck at 0 with preset=00001 -> mismatch=1 in the cycle after enablePreset, held through DONE, cleared by the next start.
REQ-035 notclear low during SHIFT -> IDLE next cycle, all outputs 0, no done pulse; start asserted while busy is ignored.

Source files
------------

// File: rtl/shift_register_sequencer.sv
// Load/rotate sequencer for an external shift register: loads a pattern, issues a
// counted number of rotate strobes, and checks the register readback against its own model.
module shift_register_sequencer #(
  parameter int WIDTH        = 5,
  parameter bit CHECK_ENABLE = 1'b1
) (
  input  logic             clockpulse,
  input  logic             notclear,
  input  logic             start,
  input  logic [WIDTH-1:0] preset,
  input  logic [4:0]       steps,
  input  logic             direction,
  input  logic             hold,
  input  logic [WIDTH-1:0] regOut,
  output logic             enablePreset,
  output logic [WIDTH-1:0] presetValue,
  output logic             shiftEnable,
  output logic             shiftLeft,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | one-cycle preset strobe to the register
  // SHIFT | one rotate per cycle while hold is low
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [4:0]       count;
  logic [WIDTH-1:0] preset_q;
  logic             left_q;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] rotated;
  logic             cmp_valid;
  logic             mismatch_q;
  logic             accept;
  logic             compare_fail;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:    state_next = (count == 5'd0) ? DONE : SHIFT;
      SHIFT:   if (!hold && count == 5'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enablePreset = (state == LOAD);
  assign shiftEnable  = (state == SHIFT) && !hold;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign presetValue  = preset_q;
  assign shiftLeft    = left_q;
  assign expected     = expected_q;

  assign rotated = left_q ? {expected_q[WIDTH-2:0], expected_q[WIDTH-1]}
                          : {expected_q[0], expected_q[WIDTH-1:1]};

  // The register updates on the same edge as expected_q, so the readback is
  // compared in the following cycle; a failure shows immediately, then sticks.
  assign compare_fail = CHECK_ENABLE && cmp_valid && (regOut != expected_q);
  assign mismatch     = CHECK_ENABLE && (mismatch_q || compare_fail);

  always_ff @(posedge clockpulse) begin
    if (!notclear) begin
      state      <= IDLE;
      count      <= '0;
      preset_q   <= '0;
      left_q     <= 1'b0;
      expected_q <= '0;
      cmp_valid  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state     <= state_next;
      cmp_valid <= enablePreset || shiftEnable;
      if (accept) begin
        preset_q   <= preset;
        count      <= steps;
        left_q     <= direction;
        mismatch_q <= 1'b0;
      end else if (compare_fail) begin
        mismatch_q <= 1'b1;
      end
      if (enablePreset) begin
        expected_q <= preset_q;
      end else if (shiftEnable) begin
        expected_q <= rotated;
        count      <= count - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Randomized bench for shift_register_sequencer: drives a model register from the DUT
// strobes and checks every cycle against a schedule computed from the sequence rules.
module tb_shift_register_sequencer;
  localparam int W = 5;

  logic         clockpulse = 1'b0;
  logic         notclear, start, direction, hold;
  logic [W-1:0] preset, regOut, presetValue, expected;
  logic [4:0]   steps;
  logic         enablePreset, shiftEnable, shiftLeft, busy, done, mismatch;

  logic [W-1:0] reg_q = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] m_exp = '0;
  int errors = 0;
  int checks = 0;

  always #5 clockpulse = ~clockpulse;

  shift_register_sequencer #(.WIDTH(W), .CHECK_ENABLE(1'b1)) dut (
    .clockpulse(clockpulse), .notclear(notclear), .start(start), .preset(preset),
    .steps(steps), .direction(direction), .hold(hold), .regOut(regOut),
    .enablePreset(enablePreset), .presetValue(presetValue), .shiftEnable(shiftEnable),
    .shiftLeft(shiftLeft), .busy(busy), .done(done), .mismatch(mismatch),
    .expected(expected)
  );

  // Controlled register with optional stuck-at-0 bits on its readback.
  always_ff @(posedge clockpulse) begin
    if (enablePreset) reg_q <= presetValue;
    else if (shiftEnable) reg_q <= shiftLeft ? {reg_q[W-2:0], reg_q[W-1]} : {reg_q[0], reg_q[W-1:1]};
  end
  assign regOut = reg_q & ~stuck0;

  function automatic logic [W-1:0] rot(input logic [W-1:0] p, input int n, input logic left);
    int s;
    logic [W-1:0] a, b;
    s = n % W;
    if (s == 0) return p;
    if (left) begin a = p << s; b = p >> (W - s); end
    else      begin a = p >> s; b = p << (W - s); end
    return a | b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input string tag, input logic e_ep, input logic e_se, input logic e_busy,
                        input logic e_done, input logic e_mis, input logic [W-1:0] e_exp);
    check({tag, ".enablePreset"}, 32'(enablePreset), 32'(e_ep));
    check({tag, ".shiftEnable"},  32'(shiftEnable),  32'(e_se));
    check({tag, ".busy"},         32'(busy),         32'(e_busy));
    check({tag, ".done"},         32'(done),         32'(e_done));
    check({tag, ".mismatch"},     32'(mismatch),     32'(e_mis));
    check({tag, ".expected"},     32'(expected),     32'(e_exp));
  endtask

  // hmode: 0 = no hold, 1 = random hold, 2 = hold in cycles 3 and 4 after acceptance
  task automatic run_seq(input string tag, input logic [W-1:0] p, input logic [4:0] n,
                         input logic dir, input int hmode, input logic [W-1:0] stuck);
    int shifts, holds, cyc;
    logic cv, mis, seen_done, h, e_se, e_done;
    logic [W-1:0] e_exp;
    shifts = 0; holds = 0; cv = 1'b0; mis = 1'b0; seen_done = 1'b0;
    stuck0 = stuck;
    start = 1'b1; preset = p; steps = n; direction = dir; hold = 1'($urandom_range(0, 1));
    @(posedge clockpulse);
    for (cyc = 1; cyc <= 70; cyc++) begin
      #1;
      if (hmode == 1)      h = ($urandom_range(0, 3) == 0) && (holds < 20);
      else if (hmode == 2) h = (cyc == 3 || cyc == 4);
      else                 h = 1'b0;
      hold      = h;
      start     = 1'($urandom_range(0, 1));
      preset    = W'($urandom);
      steps     = 5'($urandom);
      direction = 1'($urandom_range(0, 1));
      @(negedge clockpulse);
      if (cyc == 1) begin
        sample({tag, ".load"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_exp);
        cv = 1'b1;
      end else begin
        e_exp  = rot(p, shifts, dir);
        e_done = (shifts == int'(n));
        e_se   = !e_done && !h;
        if (cv && ((e_exp & stuck) != '0)) mis = 1'b1;
        sample(e_done ? {tag, ".done"} : {tag, ".shift"}, 1'b0, e_se, 1'b1, e_done, mis, e_exp);
        cv = e_se;
        if (e_se) shifts++;
        else if (!e_done) holds++;
        if (e_done) begin
          check({tag, ".done_cycle"}, 32'(cyc), 32'(2 + int'(n) + holds));
          seen_done = 1'b1;
        end
      end
      check({tag, ".presetValue"}, 32'(presetValue), 32'(p));
      check({tag, ".shiftLeft"},   32'(shiftLeft),   32'(dir));
      if (seen_done) break;
      @(posedge clockpulse);
    end
    if (!seen_done) check({tag, ".timeout"}, 32'(0), 32'(1));
    m_exp = rot(p, int'(n), dir);
    @(posedge clockpulse);
    #1; start = 1'b0; hold = 1'b0;
    @(negedge clockpulse);
    sample({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, mis, m_exp);
  endtask

  task automatic check_cleared(input string tag);
    sample(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check({tag, ".presetValue"}, 32'(presetValue), 32'(0));
    check({tag, ".shiftLeft"},   32'(shiftLeft),   32'(0));
  endtask

  task automatic reset_mid();
    start = 1'b1; preset = W'($urandom); steps = 5'd20; direction = 1'b1; hold = 1'b0;
    @(posedge clockpulse);
    #1 start = 1'b0;
    repeat (4) @(posedge clockpulse);
    #1 notclear = 1'b0; start = 1'b1; hold = 1'b1;
    @(negedge clockpulse);
    check("rst_mid.busy_before", 32'(busy), 32'(1));
    @(posedge clockpulse);
    @(negedge clockpulse);
    check_cleared("rst_mid");
    notclear = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) begin
      @(negedge clockpulse);
      check("rst_mid.no_done", 32'(done), 32'(0));
      check("rst_mid.no_busy", 32'(busy), 32'(0));
    end
    m_exp = '0;
  endtask

  initial begin
    logic [W-1:0] st;
    notclear = 1'b0; start = 1'b1; hold = 1'b1; preset = 5'b10101; steps = 5'd7; direction = 1'b1;
    repeat (2) @(posedge clockpulse);
    @(negedge clockpulse);
    check_cleared("reset");
    notclear = 1'b1;

    run_seq("rr3",     5'b11000, 5'd3,  1'b0, 0, '0);
    run_seq("steps0",  5'b10110, 5'd0,  1'b1, 0, '0);
    run_seq("hold_rl", 5'b11000, 5'd5,  1'b1, 2, '0);
    check("hold_rl.final", 32'(expected), 32'(5'b11000));
    run_seq("stuck",   5'b00001, 5'd2,  1'b0, 0, 5'b00001);
    run_seq("clear",   5'b01010, 5'd4,  1'b1, 0, '0);
    run_seq("steps31", 5'b10011, 5'd31, 1'b0, 1, '0);
    reset_mid();
    run_seq("after_rst", 5'b00111, 5'd2, 1'b1, 0, '0);

    for (int i = 0; i < 30; i++) begin
      st = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      run_seq("rand", W'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), 1, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
